// File: rtl/i2c_slave_byte_ctrl.sv
// i2c_slave_byte_ctrl: I2C target-side byte engine.
// Oversamples SCL/SDA, detects START/Sr/STOP, matches a 7-bit address and
// moves write bytes to the host (Rx strobe) or read bytes from it (Tx valid/ack).
// Optional build macro: I2C_SLAVE_STRETCH_EN (hold SCL low while no Tx byte).
module i2c_slave_byte_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Scl_i,
  input  logic              Sda_i,
  output logic              Scl_oe,
  output logic              Sda_oe,
  input  logic [ADDR_W-1:0] Slave_addr,
  output logic              Rw,
  output logic              Busy,
  output logic              Addr_match,
  output logic [7:0]        Rx_data,
  output logic              Rx_valid,
  input  logic [7:0]        Tx_data,
  input  logic              Tx_valid,
  output logic              Tx_ack,
  output logic              Tx_underrun,
  output logic              Rx_nack,
  output logic              Stop_det
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_q, sda_q, scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d, rx_data_q, rx_data_d, byte_in;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       ack_on_q, ack_on_d, sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic       rw_q, rw_d;
  logic       addr_match_q, addr_match_d, rx_valid_q, rx_valid_d;
  logic       rx_nack_q, rx_nack_d, stop_q, stop_d;
  logic       tx_take, tx_miss;

  // Pad synchronisers and edge history; left unreset so a reset mid-transfer
  // cannot fabricate a START/STOP from stale flop values.
  always_ff @(posedge Clk) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], Scl_i};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], Sda_i};
    scl_q    <= scl_sync[SYNC_STAGES-1];
    sda_q    <= sda_sync[SYNC_STAGES-1];
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & ~sda_s & sda_q;
  assign stop_det  = scl_s & scl_q & sda_s & ~sda_q;
  assign byte_in   = {shreg_q[6:0], sda_s};

  // Next-state and datapath; bus conditions override any data edge.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    ack_on_d     = ack_on_q;
    sda_oe_d     = sda_oe_q;
    scl_oe_d     = 1'b0;
    rw_d         = rw_q;
    rx_data_d    = rx_data_q;
    addr_match_d = 1'b0;
    rx_valid_d   = 1'b0;
    rx_nack_d    = 1'b0;
    stop_d       = 1'b0;
    tx_take      = 1'b0;
    tx_miss      = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      ack_on_d = 1'b0;
      bitcnt_d = 3'd0;
      stop_d   = 1'b1;
    end else if (start_det) begin
      state_d  = ADDR;
      sda_oe_d = 1'b0;
      ack_on_d = 1'b0;
      bitcnt_d = 3'd0;
    end else begin
      case (state_q)
        IDLE, IGNORE: sda_oe_d = 1'b0;
        ADDR: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (byte_in[7 -: ADDR_W] == Slave_addr) begin
                addr_match_d = 1'b1;
                rw_d         = byte_in[0];
                state_d      = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        // First fall pulls SDA for the ACK, the next fall lets it go.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              state_d  = (state_q == ADDR_ACK && rw_q) ? RD_LOAD : WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end
        RD_LOAD: begin
`ifdef I2C_SLAVE_STRETCH_EN
          if (!Tx_valid) begin
            scl_oe_d = 1'b1;
          end else begin
            tx_take  = 1'b1;
            shreg_d  = Tx_data;
            sda_oe_d = ~Tx_data[7];
            scl_oe_d = scl_oe_q;  // SCL let go one cycle after the MSB is on SDA
            bitcnt_d = 3'd0;
            state_d  = RD_DATA;
          end
`else
          if (Tx_valid) begin
            tx_take  = 1'b1;
            shreg_d  = Tx_data;
            sda_oe_d = ~Tx_data[7];
          end else begin
            tx_miss  = 1'b1;
            shreg_d  = 8'hFF;
            sda_oe_d = 1'b0;
          end
          bitcnt_d = 3'd0;
          state_d  = RD_DATA;
`endif
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              bitcnt_d = 3'd0;
              state_d  = RD_ACK;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
        RD_ACK: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            if (!sda_s) ack_on_d = 1'b1;
            else begin
              rx_nack_d = 1'b1;
              state_d   = IGNORE;
            end
          end else if (scl_fall && ack_on_q) begin
            ack_on_d = 1'b0;
            state_d  = RD_LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      shreg_q      <= 8'h00;
      bitcnt_q     <= 3'd0;
      ack_on_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      scl_oe_q     <= 1'b0;
      rw_q         <= 1'b0;
      rx_data_q    <= 8'h00;
      addr_match_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_nack_q    <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      ack_on_q     <= ack_on_d;
      sda_oe_q     <= sda_oe_d;
      scl_oe_q     <= scl_oe_d;
      rw_q         <= rw_d;
      rx_data_q    <= rx_data_d;
      addr_match_q <= addr_match_d;
      rx_valid_q   <= rx_valid_d;
      rx_nack_q    <= rx_nack_d;
      stop_q       <= stop_d;
    end
  end

  assign Scl_oe      = scl_oe_q;
  assign Sda_oe      = sda_oe_q;
  assign Rw          = rw_q;
  assign Busy        = (state_q != IDLE);
  assign Addr_match  = addr_match_q;
  assign Rx_data     = rx_data_q;
  assign Rx_valid    = rx_valid_q;
  assign Tx_ack      = tx_take;
  assign Tx_underrun = tx_miss;
  assign Rx_nack     = rx_nack_q;
  assign Stop_det    = stop_q;

endmodule
